// File: rtl/booth_seq_multiply_if.sv
// Operand/result bundle between the control unit (master) and the
// sequential Booth multiplier (slave).
interface booth_seq_multiply_if #(
  parameter int unsigned BITS = 32
);
  logic            start;
  logic            signed_mode;
  logic [BITS-1:0] multiplicand;
  logic [BITS-1:0] multiplier;
  logic            busy;
  logic            done;
  logic [BITS-1:0] result_hi;
  logic [BITS-1:0] result_lo;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, result_hi, result_lo
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, result_hi, result_lo
  );
endinterface

// File: rtl/booth_seq_multiply.sv
// Multi-cycle radix-4 Booth multiplier: one Booth group retired per clock,
// signed/unsigned operands, start/busy/done handshake, split hi/lo product.
module booth_seq_multiply #(
  parameter int unsigned BITS = 32
) (
  input logic                 clk,
  input logic                 clr,
  booth_seq_multiply_if.slave bus
);

  localparam int unsigned ITER = BITS / 2 + 1;
  localparam int unsigned AW   = 2 * BITS + 4;
  localparam int unsigned CW   = $clog2(ITER + 1);

  if (((BITS % 2) != 0) || (BITS < 4)) begin : g_bad_bits
    $error("booth_seq_multiply: BITS must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic            busy, done, load, last;

  logic [AW-1:0]   a_q;
  logic [BITS+2:0] m_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   count_q;
  logic [BITS-1:0] hi_q, lo_q;

  logic            ext_a, ext_b;
  logic [AW-1:0]   a_ext;
  logic [BITS+2:0] m_ext;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   acc_sum;

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    last    = (count_q == CW'(ITER - 1));
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier keeps an appended zero as bit -1; its low three bits are always
  // the current group because the register shifts right two places per step.
  always_comb begin
    ext_a = bus.signed_mode & bus.multiplicand[BITS-1];
    ext_b = bus.signed_mode & bus.multiplier[BITS-1];
    a_ext = {{(AW - BITS){ext_a}}, bus.multiplicand};
    m_ext = {{2{ext_b}}, bus.multiplier, 1'b0};
  end

  // Multiplicand is pre-shifted left by 2 each step instead of shifting pp by 2k.
  always_comb begin
    case (m_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + pp;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (load) begin
      a_q     <= a_ext;
      m_q     <= m_ext;
      acc_q   <= '0;
      count_q <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q << 2;
      m_q     <= {{2{m_q[BITS+2]}}, m_q[BITS+2:2]};
      acc_q   <= acc_sum;
      count_q <= count_q + 1'b1;
      if (last) begin
        hi_q <= acc_sum[2*BITS-1:BITS];
        lo_q <= acc_sum[BITS-1:0];
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result_hi = hi_q;
  assign bus.result_lo = lo_q;

endmodule
